// File: rtl/rom_streamer.sv
// Fixed-content ROM with a random-access read port and a burst streaming engine.
// The storage has a single read port; random reads win over stream fetches.
//
// state | meaning
// IDLE  | waiting for start; random reads only
// RUN   | fetching burst words into the output register
// FLUSH | last word of the burst fetched, waiting for it to be accepted
module rom_streamer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 6,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              loop,
    input  logic              abort,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int PW = DATA_W + ADDR_W + 3;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] start_lat;
    logic [LEN_W-1:0]  len_lat;
    logic [LEN_W-1:0]  remaining;
    logic              loop_lat;

    logic [ADDR_W-1:0] port_addr;
    logic [PW-1:0]     port_ext;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] rom_q;
    logic              fetch;
    logic              last_word;
    logic [ADDR_W-1:0] addr_inc;

    // Single shared read port: random access steals the cycle from the stream.
    always_comb begin
        port_addr = rd_en ? rd_addr : addr;
        port_ext  = PW'(port_addr);
        prod      = (port_ext << 2) + port_ext + PW'(1);
        rom_q     = '0;
        if ({1'b0, port_addr} < DEPTH_C) begin
            rom_q = prod[DATA_W-1:0];
        end
    end

    always_comb begin
        fetch     = (state == RUN) && (remaining != '0) && !rd_en &&
                    (!out_valid || out_ready);
        last_word = (remaining == LEN_W'(1));
        addr_inc  = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            start_lat <= '0;
            len_lat   <= '0;
            remaining <= '0;
            loop_lat  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rom_q;
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            addr      <= start_addr;
                            start_lat <= start_addr;
                            len_lat   <= len;
                            remaining <= len;
                            loop_lat  <= loop;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        remaining <= '0;
                    end else if (fetch) begin
                        out_data  <= rom_q;
                        out_valid <= 1'b1;
                        if (last_word) begin
                            if (loop_lat) begin
                                // Restart the pass immediately so looping has no bubble.
                                addr      <= start_lat;
                                remaining <= len_lat;
                            end else begin
                                state     <= FLUSH;
                                remaining <= '0;
                            end
                        end else begin
                            addr      <= addr_inc;
                            remaining <= remaining - LEN_W'(1);
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end

                FLUSH: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end else if (!out_valid || out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_streamer.sv
// Directed testbench for rom_streamer; expected values are hand-computed
// from word(i) = (5*i + 1) mod 64.
module tb_rom_streamer;

    logic       clk;
    logic       rst_n;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [5:0] rd_data;
    logic       rd_valid;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] len;
    logic       loop;
    logic       abort;
    logic [5:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    rom_streamer #(
        .ADDR_W(4),
        .DATA_W(6),
        .DEPTH (16),
        .LEN_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .start     (start),
        .start_addr(start_addr),
        .len       (len),
        .loop      (loop),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stream(input string tag, input logic [5:0] exp_data);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"}, 32'(out_data), 32'(exp_data));
    endtask

    task automatic kick(input logic [3:0] a, input logic [4:0] l, input logic lp);
        start      = 1'b1;
        start_addr = a;
        len        = l;
        loop       = lp;
        tick();
        start = 1'b0;
    endtask

    logic [5:0] rd_exp [4];
    logic [3:0] rd_adr [4];
    logic [5:0] loop_exp [5];

    initial begin
        rst_n      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        loop       = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        rd_adr   = '{4'd0, 4'd1, 4'd2, 4'd15};
        rd_exp   = '{6'd1, 6'd6, 6'd11, 6'd12};
        loop_exp = '{6'd11, 6'd16, 6'd11, 6'd16, 6'd11};

        #12;
        chk("rst.rd_valid", 32'(rd_valid), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.out_data", 32'(out_data), 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back random reads
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = rd_adr[i];
            tick();
            chk("rd.valid", 32'(rd_valid), 1);
            chk("rd.data", 32'(rd_data), 32'(rd_exp[i]));
        end
        rd_en = 1'b0;
        tick();
        chk("rd.valid_drop", 32'(rd_valid), 0);
        chk("rd.data_hold", 32'(rd_data), 12);

        // Plain burst with wrap: 14,15,0,1 -> 7,12,1,6
        kick(4'd14, 5'd4, 1'b0);
        chk("b1.busy", 32'(busy), 1);
        chk("b1.first_lat", 32'(out_valid), 0);
        tick(); chk_stream("b1.w0", 6'd7);
        tick(); chk_stream("b1.w1", 6'd12);
        tick(); chk_stream("b1.w2", 6'd1);
        tick(); chk_stream("b1.w3", 6'd6);
        chk("b1.done_early", 32'(done), 0);
        tick();
        chk("b1.done", 32'(done), 1);
        chk("b1.busy_end", 32'(busy), 0);
        chk("b1.valid_end", 32'(out_valid), 0);
        tick();
        chk("b1.done_pulse", 32'(done), 0);

        // Backpressure on the first word
        kick(4'd14, 5'd4, 1'b0);
        tick(); chk_stream("b2.w0", 6'd7);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_stream("b2.hold", 6'd7);
        end
        out_ready = 1'b1;
        tick(); chk_stream("b2.w1", 6'd12);
        tick(); chk_stream("b2.w2", 6'd1);
        tick(); chk_stream("b2.w3", 6'd6);
        tick();
        chk("b2.done", 32'(done), 1);
        chk("b2.valid_end", 32'(out_valid), 0);

        // Looping burst, then abort
        tick();
        kick(4'd2, 5'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_stream("b3.loop", loop_exp[i]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("b3.abort_valid", 32'(out_valid), 0);
        chk("b3.abort_busy", 32'(busy), 0);
        chk("b3.abort_done", 32'(done), 0);
        tick();
        chk("b3.abort_done2", 32'(done), 0);

        // Random read collides with stream fetch
        kick(4'd14, 5'd4, 1'b0);
        tick(); chk_stream("b4.w0", 6'd7);
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        chk("b4.rd_valid", 32'(rd_valid), 1);
        chk("b4.rd_data", 32'(rd_data), 16);
        chk("b4.bubble", 32'(out_valid), 0);
        tick(); chk_stream("b4.w1", 6'd12);
        chk("b4.rd_drop", 32'(rd_valid), 0);
        tick(); chk_stream("b4.w2", 6'd1);
        tick(); chk_stream("b4.w3", 6'd6);
        tick();
        chk("b4.done", 32'(done), 1);

        // Zero-length start
        tick();
        kick(4'd5, 5'd0, 1'b0);
        chk("z.done", 32'(done), 1);
        chk("z.busy", 32'(busy), 0);
        chk("z.valid", 32'(out_valid), 0);
        tick();
        chk("z.done_pulse", 32'(done), 0);
        chk("z.valid2", 32'(out_valid), 0);

        // Reset mid-burst, then a fresh burst
        kick(4'd14, 5'd4, 1'b0);
        tick(); chk_stream("r.w0", 6'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r.out_valid", 32'(out_valid), 0);
        chk("r.out_data", 32'(out_data), 0);
        chk("r.busy", 32'(busy), 0);
        chk("r.rd_data", 32'(rd_data), 0);
        #3;
        rst_n = 1'b1;
        tick();
        kick(4'd0, 5'd1, 1'b0);
        tick(); chk_stream("r.new_w0", 6'd1);
        tick();
        chk("r.new_done", 32'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_streamer.md
ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 Parameter ADDR_W, default 4, address width in bits.
REQ-002 Parameter DATA_W, default 6, word width in bits.
REQ-003 Parameter DEPTH, default 16, number of stored words; legal range 1..2**ADDR_W.
REQ-004 Parameter LEN_W, default 5, width of the burst-length input.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 rd_en  input  1  random-access read request.
REQ-008 rd_addr  input  ADDR_W  random-access read address.
REQ-009 rd_data  output  DATA_W  random-access read result.
REQ-010 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-011 start  input  1  burst start request, sampled in IDLE only.
REQ-012 start_addr  input  ADDR_W  first burst address.
REQ-013 len  input  LEN_W  number of words per burst pass.
REQ-014 loop  input  1  repeat burst indefinitely, sampled with start.
REQ-015 abort  input  1  terminate burst.
REQ-016 out_data  output  DATA_W  stream word.
REQ-017 out_valid  output  1  stream word present.
REQ-018 out_ready  input  1  downstream accepts stream word.
REQ-019 busy  output  1  high while not in IDLE.
REQ-020 done  output  1  one-cycle pulse at burst completion.

Function
REQ-021 Contents SHALL be fixed: word i = (5*i + 1) mod 2**DATA_W for i in 0..DEPTH-1; any address >= DEPTH SHALL read 0.
REQ-022 Storage SHALL have exactly one read port per cycle, shared by random and stream access.
REQ-023 rd_en high at edge k: rd_data = word(rd_addr) and rd_valid = 1 after edge k, rd_valid = 0 after edge k+1 unless rd_en again; rd_data holds its value otherwise.
REQ-024 Random read SHALL have priority over stream fetch in the same cycle; the stream fetch is deferred one cycle, never dropped.
REQ-025 FSM states: IDLE, RUN, FLUSH; reset state IDLE.
REQ-026 IDLE: start=1 with len!=0 at edge k -> RUN; start_addr, len, loop latched; first word fetched at edge k+1 (out_valid high after k+1 absent rd_en collision).
REQ-027 IDLE: start=1 with len=0 -> stay IDLE, done pulses after edge k, no data emitted.
REQ-028 start while busy SHALL be ignored.
REQ-029 Stream fetch at edge j SHALL occur when in RUN, words remain in pass, no rd_en, and (out_valid=0 or out_ready=1); loads out_data, sets out_valid -> full throughput of one word per cycle.
REQ-030 out_valid=1 and out_ready=0: out_data and out_valid SHALL be held unchanged.
REQ-031 Stream address SHALL increment by 1 and wrap from DEPTH-1 to 0.
REQ-032 After the last word of a pass is fetched: loop=1 -> next fetch restarts at latched start_addr with no bubble; loop=0 -> FLUSH.
REQ-033 FLUSH: when the final word is accepted (out_valid & out_ready) -> IDLE, out_valid=0, done pulses one cycle after that edge.
REQ-034 abort=1 in RUN or FLUSH at edge k -> IDLE, out_valid=0 after edge k, no done pulse; abort in IDLE ignored; abort has priority over all other transitions.
REQ-035 busy SHALL equal (state != IDLE) registered.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE and rd_data=0, rd_valid=0, out_data=0, out_valid=0, busy=0, done=0, internal address/counters=0.
REQ-037 Reset mid-burst SHALL discard the burst; after release the block accepts a new start normally.

Verification
REQ-038 rd_en with rd_addr=0,1,2,15 on consecutive cycles -> rd_data 1,6,11,12 each one cycle later, rd_valid high four cycles.
REQ-039 start, start_addr=14, len=4, loop=0, out_ready=1 -> out_data 7,12,1,6 on four consecutive cycles, then done pulse, busy=0.
REQ-040 Same burst with out_ready=0 for 3 cycles after first word -> out_data=7 held stable, sequence unchanged, no word lost or duplicated.
REQ-041 start_addr=2, len=2, loop=1 -> 11,16,11,16,... without bubbles; abort -> out_valid=0 next cycle, no done.
REQ-042 rd_en asserted during a burst -> one-cycle stream bubble, stream order preserved, rd_data correct.
REQ-043 start with len=0 -> done pulse, out_valid never high; rst_n low mid-burst -> all outputs 0 immediately.
